// File: rtl/vga_timing.sv
// VGA raster timing generator.
// Free-running pixel/line counters advanced by a pixel-step enable, with
// registered sync, display-enable, prefetch and line/frame pulse outputs.
// All decoded outputs are computed from the *next* counter values, so they
// change on the same PIXELCLK edge as the HPOS/VPOS values they describe.
module vga_timing #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter bit SYNC_POL   = 1'b1,
    parameter int FETCH_LEAD = 2,
    parameter int CW         = 11
) (
    input  logic          PIXELCLK,
    input  logic          nRESET,
    input  logic          CE,
    output logic          VGA_HSYNC,
    output logic          VGA_VSYNC,
    output logic          DISEN,
    output logic          PREFETCH,
    output logic          NEWLINE,
    output logic          NEWSCREEN,
    output logic          FIELD,
    output logic [CW-1:0] HPOS,
    output logic [CW-1:0] VPOS
);

    localparam int H_TOTAL   = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL   = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START  = H_ACTIVE + H_FRONT;
    localparam int HS_END    = H_ACTIVE + H_FRONT + H_SYNC;
    localparam int VS_START  = V_ACTIVE + V_FRONT;
    localparam int VS_END    = V_ACTIVE + V_FRONT + V_SYNC;

    // Reject parameter sets the counters or the prefetch wrap cannot support.
    if ((H_TOTAL - 1) >= (1 << CW)) begin : g_bad_cw_h
        $fatal(1, "vga_timing: CW too narrow for H_TOTAL-1");
    end
    if ((V_TOTAL - 1) >= (1 << CW)) begin : g_bad_cw_v
        $fatal(1, "vga_timing: CW too narrow for V_TOTAL-1");
    end
    if (H_SYNC == 0 || V_SYNC == 0) begin : g_bad_sync
        $fatal(1, "vga_timing: sync width must be non-zero");
    end
    if (FETCH_LEAD < 0 || FETCH_LEAD > H_BACK) begin : g_bad_lead
        $fatal(1, "vga_timing: FETCH_LEAD must be within 0..H_BACK");
    end

    logic          h_wrap;
    logic          v_wrap;
    logic [CW-1:0] next_h;
    logic [CW-1:0] next_v;
    logic          hsync_d;
    logic          vsync_d;
    logic          disen_d;
    logic          prefetch_d;
    logic          newline_d;
    logic          newscreen_d;
    int            nh;
    int            nv;
    int            ph;
    int            pv;

    // Next position and the output values that position decodes to.
    always_comb begin
        h_wrap      = (HPOS == CW'(H_TOTAL - 1));
        v_wrap      = (VPOS == CW'(V_TOTAL - 1));
        next_h      = h_wrap ? '0 : HPOS + CW'(1);
        next_v      = VPOS;
        if (h_wrap) begin
            next_v = v_wrap ? '0 : VPOS + CW'(1);
        end
        nh          = int'(next_h);
        nv          = int'(next_v);
        hsync_d     = (nh >= HS_START && nh < HS_END) ? SYNC_POL : ~SYNC_POL;
        vsync_d     = (nv >= VS_START && nv < VS_END) ? SYNC_POL : ~SYNC_POL;
        disen_d     = (nh < H_ACTIVE) && (nv < V_ACTIVE);
        // Look FETCH_LEAD steps ahead; the lead never exceeds the back porch,
        // so at most one line wrap has to be accounted for.
        ph          = nh + FETCH_LEAD;
        pv          = nv;
        if (ph >= H_TOTAL) begin
            ph = ph - H_TOTAL;
            pv = (nv == V_TOTAL - 1) ? 0 : nv + 1;
        end
        prefetch_d  = (ph < H_ACTIVE) && (pv < V_ACTIVE);
        newline_d   = CE && (nh == H_ACTIVE);
        newscreen_d = newline_d && (nv == V_ACTIVE - 1);
    end

    // Counters and registered outputs; pulses are re-evaluated every clock so
    // they never stretch while CE is low.
    always_ff @(posedge PIXELCLK or negedge nRESET) begin
        if (!nRESET) begin
            HPOS      <= '0;
            VPOS      <= CW'(V_ACTIVE);
            FIELD     <= 1'b0;
            VGA_HSYNC <= ~SYNC_POL;
            VGA_VSYNC <= ~SYNC_POL;
            DISEN     <= 1'b0;
            PREFETCH  <= 1'b0;
            NEWLINE   <= 1'b0;
            NEWSCREEN <= 1'b0;
        end else begin
            NEWLINE   <= newline_d;
            NEWSCREEN <= newscreen_d;
            if (CE) begin
                HPOS      <= next_h;
                VPOS      <= next_v;
                FIELD     <= FIELD ^ (h_wrap && v_wrap);
                VGA_HSYNC <= hsync_d;
                VGA_VSYNC <= vsync_d;
                DISEN     <= disen_d;
                PREFETCH  <= prefetch_d;
            end
        end
    end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 H_ACTIVE, 640, visible pixels per line.
REQ-002 H_FRONT, 16, horizontal front-porch pixels.
REQ-003 H_SYNC, 96, horizontal sync-pulse pixels.
REQ-004 H_BACK, 48, horizontal back-porch pixels.
REQ-005 V_ACTIVE, 480, visible lines per frame.
REQ-006 V_FRONT, 10, vertical front-porch lines.
REQ-007 V_SYNC, 2, vertical sync-pulse lines.
REQ-008 V_BACK, 33, vertical back-porch lines.
REQ-009 SYNC_POL, 1, asserted level of VGA_HSYNC and VGA_VSYNC.
REQ-010 FETCH_LEAD, 2, pixel steps by which PREFETCH leads DISEN (0..H_BACK).
REQ-011 CW, 11, width of HPOS/VPOS.
REQ-012 PIXELCLK  in  1  sole clock, rising edge.
REQ-013 nRESET  in  1  reset, asynchronous, active-low.
REQ-014 CE  in  1  pixel-step enable; state advances only on PIXELCLK edges with CE=1.
REQ-015 VGA_HSYNC  out  1  horizontal sync.
REQ-016 VGA_VSYNC  out  1  vertical sync.
REQ-017 DISEN  out  1  current position is visible.
REQ-018 PREFETCH  out  1  DISEN advanced by FETCH_LEAD pixel steps, for video memory latency.
REQ-019 NEWLINE  out  1  one-PIXELCLK pulse at start of horizontal blanking.
REQ-020 NEWSCREEN  out  1  one-PIXELCLK pulse at start of vertical blanking.
REQ-021 FIELD  out  1  frame parity.
REQ-022 HPOS  out  CW  current pixel column.
REQ-023 VPOS  out  CW  current line.

Function
REQ-024 H_TOTAL=H_ACTIVE+H_FRONT+H_SYNC+H_BACK and V_TOTAL=sum of V_* values; elaboration SHALL fail if CW cannot hold H_TOTAL-1 or V_TOTAL-1, if any sync width is 0, or if FETCH_LEAD>H_BACK.
REQ-025 On each CE step, HPOS SHALL increment and wrap from H_TOTAL-1 to 0; VPOS SHALL increment only on that wrap and wrap from V_TOTAL-1 to 0; FIELD SHALL toggle when VPOS wraps.
REQ-026 Line order SHALL be active, front porch, sync, back porch; the same order SHALL apply vertically, in whole lines.
REQ-027 VGA_HSYNC SHALL equal SYNC_POL while H_ACTIVE+H_FRONT <= HPOS < H_ACTIVE+H_FRONT+H_SYNC, and ~SYNC_POL otherwise.
REQ-028 VGA_VSYNC SHALL equal SYNC_POL while V_ACTIVE+V_FRONT <= VPOS < V_ACTIVE+V_FRONT+V_SYNC; it SHALL change only on steps where HPOS becomes 0.
REQ-029 DISEN SHALL equal (HPOS<H_ACTIVE)&&(VPOS<V_ACTIVE).
REQ-030 PREFETCH SHALL equal the DISEN value due FETCH_LEAD steps later, including across line wrap; for VPOS=0 it SHALL rise in line V_TOTAL-1; FETCH_LEAD=0 SHALL make PREFETCH identical to DISEN.
REQ-031 All outputs SHALL be registered and change on the same PIXELCLK edge as the HPOS/VPOS values they decode; there SHALL be zero latency between HPOS/VPOS and the decoded outputs.
REQ-032 NEWLINE SHALL be high for exactly one PIXELCLK cycle following the step that sets HPOS=H_ACTIVE, regardless of CE in that cycle.
REQ-033 NEWSCREEN SHALL be high for exactly one PIXELCLK cycle following the step that sets HPOS=H_ACTIVE with VPOS=V_ACTIVE-1, coincident with that NEWLINE.
REQ-034 With CE=0, HPOS, VPOS, FIELD, the syncs, DISEN and PREFETCH SHALL hold their values; pulses SHALL NOT stretch.

Reset
REQ-035 nRESET low SHALL immediately force HPOS=0, VPOS=V_ACTIVE, FIELD=0, both syncs=~SYNC_POL, DISEN=0, PREFETCH=0, NEWLINE=0 and NEWSCREEN=0, independent of PIXELCLK.
REQ-036 After reset release, the first CE step SHALL set HPOS=1; no NEWLINE or NEWSCREEN pulse SHALL be generated by reset itself.
REQ-037 Reset asserted mid-frame SHALL abandon the frame with no partial pulses after assertion.

Verification
REQ-038 Defaults, CE=1 -> HSYNC period 800 cycles, high 96 cycles from HPOS=656; VSYNC high for VPOS 490-491 (1600 cycles); frame 420000 cycles; FIELD toggles once per frame.
REQ-039 Defaults, CE toggling 1/0 -> all periods double; NEWLINE/NEWSCREEN remain 1 PIXELCLK wide; 525 NEWLINE pulses and 1 NEWSCREEN pulse per frame.
REQ-040 Defaults -> 307200 DISEN-high steps per frame; PREFETCH rises at HPOS=798 VPOS=524 and at HPOS=798 on lines 0-478, and falls at HPOS=638.
REQ-041 Reset asserted at HPOS=300 VPOS=200 between edges -> all outputs at REQ-035 values before the next edge; frame timing restarts per REQ-036.
REQ-042 H 8/2/2/2, V 4/1/1/1, SYNC_POL=0, FETCH_LEAD=0, CW=4 -> cycle-exact match to a reference model over 3 frames; syncs active-low; PREFETCH==DISEN.
